regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised successor register file for the pipelined core: NRD combinational read ports,
//  two write ports (WB0 = ALU writeback, WB1 = load writeback) with same-cycle write-through
//  forwarding, per-register reset values, an optional hardwired-zero R0, and a busy scoreboard
//  that tracks issued-but-not-written destinations so decode can detect RAW/WAW hazards.
// PARAMETERS
//  DSIZE     16           data width per register
//  ASIZE     4            register address width
//  NREG      16           register count, must be <= 2**ASIZE
//  NRD       2            number of read ports
//  ZERO_R0   0            1: R0 reads 0, ignores writes, is never busy
//  INIT_VEC  {NREG*DSIZE{1'b0}}  reset image; register i = INIT_VEC[i*DSIZE +: DSIZE]
// PORTS
//  clk       in   1            clock, rising edge
//  rst       in   1            asynchronous, active-low reset
//  wen0      in   1            write enable, port 0
//  waddr0    in   ASIZE        write address, port 0
//  wdata0    in   DSIZE        write data, port 0
//  wen1      in   1            write enable, port 1 (higher priority)
//  waddr1    in   ASIZE        write address, port 1
//  wdata1    in   DSIZE        write data, port 1
//  raddr     in   NRD*ASIZE    read addresses; port i = raddr[i*ASIZE +: ASIZE]
//  rdata     out  NRD*DSIZE    read data; port i = rdata[i*DSIZE +: DSIZE]
//  rbusy     out  NRD          read port i addresses a register still pending
//  iss_en    in   1            decode issues an instruction that writes iss_addr
//  iss_addr  in   ASIZE        destination of the issuing instruction
//  iss_ok    out  1            issue is accepted this cycle
//  nbusy     out  ASIZE+1      number of busy registers
// BEHAVIOUR
//  Reset (rst=0, asynchronous): reg[i] <= INIT_VEC slice (R0 <= 0 when ZERO_R0); all busy
//    bits <= 0; nbusy = 0. rbusy = 0 and iss_ok = 1 while reset is held. Deassertion is
//    synchronised externally.
//  Write (posedge clk): wenK=1 writes wdataK to reg[waddrK]. If both ports target the same
//    address, port 1's data is stored. Writes to addresses >= NREG are dropped. With ZERO_R0,
//    writes to R0 are dropped.
//  Read (combinational, 0-cycle latency), per port i, first matching rule wins:
//    ZERO_R0 && raddr==0 -> 0; wen1 && waddr1==raddr -> wdata1;
//    wen0 && waddr0==raddr -> wdata0; otherwise reg[raddr]. Addresses >= NREG read 0.
//  Scoreboard: busy[NREG] flags.
//    A write on either port clears busy[waddr] at the clock edge.
//    iss_en && iss_ok sets busy[iss_addr] at the clock edge. If the same edge also clears
//      that address, the set wins.
//    iss_ok = !iss_en || iss_addr>=NREG || (ZERO_R0 && iss_addr==0) || !busy[iss_addr]
//      || the register is written this cycle. This is a WAW stall.
//    Issues to R0 (ZERO_R0) or to addresses >= NREG never set busy.
//    rbusy[i] = busy[raddr_i] && raddr_i is not written this cycle (forwarding resolves it).
//  nbusy: registered population count of busy; it tracks busy exactly and updates on the
//    same edge. Each cycle it changes by +1, -1, -2 or 0; the set/clear interaction above
//    is accounted for. Range is 0..NREG with no wrap.
//  Reset mid-operation clears all busy bits and restores INIT_VEC regardless of pending writes.
// TESTING
//  1 Reset with INIT_VEC reg4=0x0000, reg8=0x0008, reg9=0x0010 -> rdata shows these values,
//    rbusy=0, nbusy=0, and values remain after the first clk.
//  2 wen0 waddr0=3 wdata0=0x1234 with raddr0=3 in the same cycle -> rdata0=0x1234
//    combinationally; after the edge, with wen0=0, rdata0 still reads 0x1234.
//  3 wen0=wen1=1, both to reg5, wdata0=0xAAAA, wdata1=0x5555 -> forwarded rdata=0x5555 and
//    stored value 0x5555.
//  4 Issue reg7 -> busy, nbusy=1, rbusy=1 on a read of 7. Issue reg7 again -> iss_ok=0.
//    wen1 to reg7 plus issue reg7 in the same cycle -> iss_ok=1, rbusy=0 that cycle;
//    reg7 stays busy, nbusy=1.
//  5 ZERO_R0=1: write 0xFFFF to R0 and issue R0 -> rdata=0, iss_ok=1, nbusy unchanged.
//  6 Busy regs 1,2,3 (nbusy=3), pull rst low between edges -> immediately nbusy=0, rbusy=0,
//    and registers equal INIT_VEC.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write-through forwarding and busy scoreboard
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   wen0_i/waddr0_i/wdata0_i write port 0 (ALU writeback)
//   wen1_i/waddr1_i/wdata1_i write port 1 (load writeback, wins on address collision)
//   raddr_i / rdata_o        NRD packed read addresses / combinational read data
//   rbusy_o                  per read port: addressed register still pending
//   iss_en_i/iss_addr_i      decode issues an instruction writing iss_addr_i
//   iss_ok_o                 issue accepted (no WAW stall)
//   nbusy_o                  number of busy registers
module regfile_mp_sb #(
    parameter int                    DSIZE    = 16,
    parameter int                    ASIZE    = 4,
    parameter int                    NREG     = 16,
    parameter int                    NRD      = 2,
    parameter bit                    ZERO_R0  = 1'b0,
    parameter logic [NREG*DSIZE-1:0] INIT_VEC = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wen0_i,
    input  logic [ASIZE-1:0]       waddr0_i,
    input  logic [DSIZE-1:0]       wdata0_i,
    input  logic                   wen1_i,
    input  logic [ASIZE-1:0]       waddr1_i,
    input  logic [DSIZE-1:0]       wdata1_i,
    input  logic [NRD*ASIZE-1:0]   raddr_i,
    output logic [NRD*DSIZE-1:0]   rdata_o,
    output logic [NRD-1:0]         rbusy_o,
    input  logic                   iss_en_i,
    input  logic [ASIZE-1:0]       iss_addr_i,
    output logic                   iss_ok_o,
    output logic [ASIZE:0]         nbusy_o
);
    localparam int NA = 2 ** ASIZE;
    logic [DSIZE-1:0] regs_q [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [NA-1:0]    busy_x;
    logic [ASIZE:0]   nbusy_q, nbusy_d;
    logic             we0, we1, iss_set;
    // an address names a real, writable register (not out of range, not hardwired R0)
    function automatic logic valid(input logic [ASIZE-1:0] a);
        return ({1'b0, a} < (ASIZE+1)'(NREG)) && !(ZERO_R0 && a == '0);
    endfunction
    function automatic logic hit(input logic [ASIZE-1:0] a);
        return (wen0_i && waddr0_i == a) || (wen1_i && waddr1_i == a);
    endfunction
    // busy vector widened to the full address space so any address indexes it safely
    assign busy_x   = NA'(busy_q);
    assign we0      = wen0_i && valid(waddr0_i);
    assign we1      = wen1_i && valid(waddr1_i);
    assign iss_ok_o = !iss_en_i || !valid(iss_addr_i) || !busy_x[iss_addr_i] || hit(iss_addr_i);
    assign iss_set  = iss_en_i && iss_ok_o && valid(iss_addr_i);
    assign nbusy_o  = nbusy_q;
    // a same-edge issue to a register being written re-marks it busy
    always_comb begin
        busy_d  = busy_q;
        nbusy_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_d[i] = (iss_set && iss_addr_i == ASIZE'(i)) ? 1'b1 : hit(ASIZE'(i)) ? 1'b0 : busy_q[i];
            nbusy_d   = nbusy_d + (ASIZE+1)'(busy_d[i]);
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= (ZERO_R0 && i == 0) ? '0 : INIT_VEC[i*DSIZE +: DSIZE];
            busy_q  <= '0;
            nbusy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we1 && waddr1_i == ASIZE'(i))
                    regs_q[i] <= wdata1_i;
                else if (we0 && waddr0_i == ASIZE'(i))
                    regs_q[i] <= wdata0_i;
            end
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
        end
    end
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ASIZE-1:0] ra;
        assign ra = raddr_i[p*ASIZE +: ASIZE];
        // write-through: a register written this cycle reads its new value and is no longer pending
        assign rdata_o[p*DSIZE +: DSIZE] = !valid(ra) ? '0 :
                                           (wen1_i && waddr1_i == ra) ? wdata1_i :
                                           (wen0_i && waddr0_i == ra) ? wdata0_i : regs_q[ra];
        assign rbusy_o[p] = busy_x[ra] && !hit(ra);
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: randomized + directed check of regfile_mp_sb against a behavioural model
module tb_regfile_mp_sb;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 12;

    function automatic logic [DW-1:0] init_of(int i);
        return (i == 4) ? 16'h0000 : (i == 8) ? 16'h0008 : (i == 9) ? 16'h0010 : 16'hA000 + 16'(i);
    endfunction
    function automatic logic [NR*DW-1:0] mk_init();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = init_of(i);
        return v;
    endfunction
    localparam logic [NR*DW-1:0] INIT = mk_init();

    logic clk = 1'b0;
    logic rst_n;
    logic wen0, wen1, iss_en;
    logic [AW-1:0] waddr0, waddr1, iss_addr;
    logic [DW-1:0] wdata0, wdata1;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata_a, rdata_b;
    logic [1:0] rbusy_a, rbusy_b;
    logic iss_ok_a, iss_ok_b;
    logic [AW:0] nbusy_a, nbusy_b;

    always #5 clk = ~clk;

    regfile_mp_sb #(.DSIZE(DW), .ASIZE(AW), .NREG(NR), .NRD(2), .ZERO_R0(1'b0), .INIT_VEC(INIT)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1), .raddr_i(raddr), .rdata_o(rdata_a),
        .rbusy_o(rbusy_a), .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_ok_o(iss_ok_a), .nbusy_o(nbusy_a));
    regfile_mp_sb #(.DSIZE(DW), .ASIZE(AW), .NREG(NR), .NRD(2), .ZERO_R0(1'b1), .INIT_VEC(INIT)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1), .raddr_i(raddr), .rdata_o(rdata_b),
        .rbusy_o(rbusy_b), .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_ok_o(iss_ok_b), .nbusy_o(nbusy_b));

    // model: index 0 = plain R0, index 1 = hardwired-zero R0
    logic [DW-1:0] m_reg [2][NR];
    bit m_busy [2][NR];
    int n_vec = 0;
    int n_err = 0;

    function automatic bit wr_hit(logic [AW-1:0] a);
        return (wen0 && waddr0 == a) || (wen1 && waddr1 == a);
    endfunction
    function automatic bit writable(int k, logic [AW-1:0] a);
        return (int'(a) < NR) && !(k == 1 && a == 0);
    endfunction
    function automatic logic [DW-1:0] e_rd(int k, logic [AW-1:0] a);
        if (!writable(k, a)) return '0;
        if (wen1 && waddr1 == a) return wdata1;
        if (wen0 && waddr0 == a) return wdata0;
        return m_reg[k][a];
    endfunction
    function automatic bit e_rbusy(int k, logic [AW-1:0] a);
        return (int'(a) < NR) && m_busy[k][a] && !wr_hit(a);
    endfunction
    function automatic bit e_ok(int k);
        if (!iss_en || !writable(k, iss_addr)) return 1'b1;
        return !m_busy[k][iss_addr] || wr_hit(iss_addr);
    endfunction
    function automatic int e_nbusy(int k);
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[k][i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) begin
                m_reg[k][i] = (k == 1 && i == 0) ? '0 : init_of(i);
                m_busy[k][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        bit ok;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            ok = e_ok(k);
            if (wen0 && writable(k, waddr0)) m_reg[k][waddr0] = wdata0;
            if (wen1 && writable(k, waddr1)) m_reg[k][waddr1] = wdata1;
            if (wen0 && int'(waddr0) < NR) m_busy[k][waddr0] = 1'b0;
            if (wen1 && int'(waddr1) < NR) m_busy[k][waddr1] = 1'b0;
            if (iss_en && ok && writable(k, iss_addr)) m_busy[k][iss_addr] = 1'b1;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [AW-1:0] a;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                a = raddr[p*AW +: AW];
                chk($sformatf("rdata%0d[%0d]", k, p), 32'(k == 0 ? rdata_a[p*DW +: DW] : rdata_b[p*DW +: DW]), 32'(e_rd(k, a)));
                chk($sformatf("rbusy%0d[%0d]", k, p), 32'(k == 0 ? rbusy_a[p] : rbusy_b[p]), 32'(e_rbusy(k, a)));
            end
            chk($sformatf("iss_ok%0d", k), 32'(k == 0 ? iss_ok_a : iss_ok_b), 32'(e_ok(k)));
            chk($sformatf("nbusy%0d", k), 32'(k == 0 ? nbusy_a : nbusy_b), 32'(e_nbusy(k)));
        end
    endtask

    task automatic settle();
        #1 check_all();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; iss_en = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; iss_addr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        raddr = {4'd8, 4'd4};
        model_reset();
        @(negedge clk);
        // reset image
        settle();
        chk("t1_r4", 32'(rdata_a[15:0]), 32'h0000);
        chk("t1_r8", 32'(rdata_a[31:16]), 32'h0008);
        chk("t1_rbusy", 32'(rbusy_a), 32'h0);
        chk("t1_nbusy", 32'(nbusy_a), 32'h0);
        raddr = {4'd9, 4'd9};
        settle();
        chk("t1_r9", 32'(rdata_a[15:0]), 32'h0010);
        rst_n = 1'b1;
        edge_step();
        settle();
        chk("t1_r9_after_clk", 32'(rdata_a[15:0]), 32'h0010);
        // write-through then stored
        wen0 = 1; waddr0 = 3; wdata0 = 16'h1234; raddr = {4'd0, 4'd3};
        settle();
        chk("t2_fwd", 32'(rdata_a[15:0]), 32'h1234);
        edge_step();
        wen0 = 0;
        settle();
        chk("t2_stored", 32'(rdata_a[15:0]), 32'h1234);
        // dual write collision
        wen0 = 1; wen1 = 1; waddr0 = 5; waddr1 = 5; wdata0 = 16'hAAAA; wdata1 = 16'h5555; raddr = {4'd5, 4'd5};
        settle();
        chk("t3_fwd", 32'(rdata_a[15:0]), 32'h5555);
        edge_step();
        idle();
        settle();
        chk("t3_stored", 32'(rdata_a[31:16]), 32'h5555);
        // scoreboard
        iss_en = 1; iss_addr = 7; raddr = {4'd7, 4'd7};
        settle();
        chk("t4_first_ok", 32'(iss_ok_a), 32'h1);
        edge_step();
        settle();
        chk("t4_waw_stall", 32'(iss_ok_a), 32'h0);
        chk("t4_nbusy1", 32'(nbusy_a), 32'h1);
        chk("t4_rbusy", 32'(rbusy_a[0]), 32'h1);
        edge_step();
        wen1 = 1; waddr1 = 7; wdata1 = 16'h7777;
        settle();
        chk("t4_ok_with_write", 32'(iss_ok_a), 32'h1);
        chk("t4_rbusy_fwd", 32'(rbusy_a[0]), 32'h0);
        chk("t4_rdata_fwd", 32'(rdata_a[15:0]), 32'h7777);
        edge_step();
        idle();
        settle();
        chk("t4_still_busy", 32'(nbusy_a), 32'h1);
        chk("t4_rbusy_again", 32'(rbusy_a[1]), 32'h1);
        // hardwired R0
        wen0 = 1; waddr0 = 0; wdata0 = 16'hFFFF; iss_en = 1; iss_addr = 0; raddr = {4'd0, 4'd0};
        settle();
        chk("t5_r0_read", 32'(rdata_b[15:0]), 32'h0000);
        chk("t5_r0_ok", 32'(iss_ok_b), 32'h1);
        edge_step();
        idle();
        settle();
        chk("t5_nbusy", 32'(nbusy_b), 32'h1);
        chk("t5_r0_stored", 32'(rdata_b[31:16]), 32'h0000);
        chk("t5_plain_r0", 32'(rdata_a[15:0]), 32'hFFFF);
        // mid-operation reset
        rst_n = 1'b0;
        model_reset();
        settle();
        rst_n = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            iss_en = 1; iss_addr = 4'(r);
            settle();
            edge_step();
        end
        idle();
        raddr = {4'd2, 4'd1};
        settle();
        chk("t6_nbusy3", 32'(nbusy_a), 32'h3);
        chk("t6_rbusy", 32'(rbusy_a), 32'h3);
        rst_n = 1'b0;
        model_reset();
        settle();
        chk("t6_nbusy0", 32'(nbusy_a), 32'h0);
        chk("t6_rbusy0", 32'(rbusy_a), 32'h0);
        chk("t6_r1_init", 32'(rdata_a[15:0]), 32'hA001);
        chk("t6_r2_init", 32'(rdata_a[31:16]), 32'hA002);
        edge_step();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            if (!rst_n) model_reset();
            wen0     = ($urandom_range(0, 9) < 4);
            wen1     = ($urandom_range(0, 9) < 3);
            waddr0   = 4'($urandom_range(0, 15));
            waddr1   = ($urandom_range(0, 3) == 0) ? waddr0 : 4'($urandom_range(0, 15));
            wdata0   = 16'($urandom);
            wdata1   = 16'($urandom);
            iss_en   = ($urandom_range(0, 9) < 6);
            iss_addr = 4'($urandom_range(0, 15));
            raddr    = {4'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? iss_addr : 4'($urandom_range(0, 15))};
            settle();
            edge_step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
